// File: rtl/line_fill_memory.sv
// line_fill_memory: backing store on the cache miss path. It serves whole-line
// fill reads and dirty-line write-backs after a fixed access latency.
// Optional build macro LINE_FILL_MEMORY_PATTERN_INIT_EN: when defined, each word
// starts out holding 32'hA5000000 | word_address. When it is not defined, every
// word starts at zero.
module line_fill_memory #(
    parameter int ADDR_W   = 17,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32,
    parameter int LATENCY  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-OFFSET_W-1:0]   req_line_addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         wdata_valid,
    output logic                         wdata_ready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rdata_valid,
    output logic                         rdata_last,
    output logic                         wr_done,
    output logic                         busy
);
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LCNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD, S_WR} state_t;

    state_t               r_state, w_state_nxt;
    logic [LCNT_W-1:0]    r_lcnt, w_lcnt_nxt;
    logic [OFFSET_W-1:0]  r_beat, w_beat_nxt;
    logic                 r_write, w_write_nxt;
    logic [LINE_W-1:0]    r_line, w_line_nxt;
    logic                 r_req_ready, w_req_ready_nxt;
    logic                 r_wdata_ready, w_wdata_ready_nxt;
    logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
    logic                 r_rvalid, w_rvalid_nxt;
    logic                 r_rlast, w_rlast_nxt;
    logic                 r_wr_done, w_wr_done_nxt;
    logic                 r_busy;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_pat;
    logic [DATA_W-1:0]    w_rd_word;

    // Zero-initialised storage. Reset never touches it.
    logic [DATA_W-1:0]    r_mem [DEPTH] = '{default: '0};

    assign w_addr = {r_line, r_beat};

    // The initial pattern is folded in by XOR on both the read and the write
    // path. A zeroed array therefore reads back as the pattern, and no time-0
    // load loop is needed.
`ifdef LINE_FILL_MEMORY_PATTERN_INIT_EN
    assign w_pat = DATA_W'(32'hA500_0000) | DATA_W'(w_addr);
`else
    assign w_pat = '0;
`endif

    assign w_rd_word = r_mem[w_addr] ^ w_pat;

    // Next-state and next-output decode. Single-cycle strobes default low.
    always_comb begin
        w_state_nxt       = r_state;
        w_lcnt_nxt        = r_lcnt;
        w_beat_nxt        = r_beat;
        w_write_nxt       = r_write;
        w_line_nxt        = r_line;
        w_req_ready_nxt   = r_req_ready;
        w_wdata_ready_nxt = r_wdata_ready;
        w_rdata_nxt       = r_rdata;
        w_rvalid_nxt      = 1'b0;
        w_rlast_nxt       = 1'b0;
        w_wr_done_nxt     = 1'b0;
        w_mem_we          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_write_nxt     = req_write;
                    w_line_nxt      = req_line_addr;
                    w_req_ready_nxt = 1'b0;
                    if (LATENCY > 0) begin
                        w_state_nxt = S_WAIT;
                        w_lcnt_nxt  = LCNT_W'(LATENCY);
                    end else begin
                        w_state_nxt = req_write ? S_WR : S_RD;
                    end
                end
            end
            S_WAIT: begin
                // Enter the burst state one edge early. The first read beat and
                // wdata_ready are both registered on the next edge, E0+LATENCY+1.
                w_lcnt_nxt = r_lcnt - 1'b1;
                if (r_lcnt == LCNT_W'(1))
                    w_state_nxt = r_write ? S_WR : S_RD;
            end
            S_RD: begin
                if (r_rlast) begin
                    w_state_nxt     = S_IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_rdata_nxt  = w_rd_word;
                    w_rvalid_nxt = 1'b1;
                    w_rlast_nxt  = &r_beat;
                    w_beat_nxt   = r_beat + 1'b1;
                end
            end
            S_WR: begin
                w_wdata_ready_nxt = 1'b1;
                // A beat is consumed only once ready has been shown to the cache.
                if (r_wdata_ready && wdata_valid) begin
                    w_mem_we   = 1'b1;
                    w_beat_nxt = r_beat + 1'b1;
                    if (&r_beat) begin
                        w_wdata_ready_nxt = 1'b0;
                        w_wr_done_nxt     = 1'b1;
                        w_state_nxt       = S_IDLE;
                        w_req_ready_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs. An async reset aborts any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_lcnt        <= '0;
            r_beat        <= '0;
            r_write       <= 1'b0;
            r_line        <= '0;
            r_req_ready   <= 1'b1;
            r_wdata_ready <= 1'b0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
            r_rlast       <= 1'b0;
            r_wr_done     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lcnt        <= w_lcnt_nxt;
            r_beat        <= w_beat_nxt;
            r_write       <= w_write_nxt;
            r_line        <= w_line_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_wdata_ready <= w_wdata_ready_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rvalid      <= w_rvalid_nxt;
            r_rlast       <= w_rlast_nxt;
            r_wr_done     <= w_wr_done_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    // Write-back beat commit. There is no reset, so the contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_addr] <= wdata ^ w_pat;
    end

    assign req_ready   = r_req_ready;
    assign wdata_ready = r_wdata_ready;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rvalid;
    assign rdata_last  = r_rlast;
    assign wr_done     = r_wr_done;
    assign busy        = r_busy;

endmodule

// File: tb/tb_line_fill_memory.sv
// tb_line_fill_memory: randomized checks of line_fill_memory against a
// word-level memory model. Two instances are used, LATENCY=3 and LATENCY=0.
// Only one instance is driven at a time, selected by sel0.
module tb_line_fill_memory;
    localparam int LINE_W = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sel0 = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [LINE_W-1:0] req_line_addr = '0;
    logic [31:0]       wdata = '0;
    logic              wdata_valid = 1'b0;

    logic        a_req_ready, a_wdata_ready, a_rdata_valid, a_rdata_last, a_wr_done, a_busy;
    logic        z_req_ready, z_wdata_ready, z_rdata_valid, z_rdata_last, z_wr_done, z_busy;
    logic [31:0] a_rdata, z_rdata;
    logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    line_fill_memory #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel0), .req_ready(a_req_ready),
        .req_write(req_write), .req_line_addr(req_line_addr),
        .wdata(wdata), .wdata_valid(wdata_valid & ~sel0), .wdata_ready(a_wdata_ready),
        .rdata(a_rdata), .rdata_valid(a_rdata_valid), .rdata_last(a_rdata_last),
        .wr_done(a_wr_done), .busy(a_busy)
    );

    line_fill_memory #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel0), .req_ready(z_req_ready),
        .req_write(req_write), .req_line_addr(req_line_addr),
        .wdata(wdata), .wdata_valid(wdata_valid & sel0), .wdata_ready(z_wdata_ready),
        .rdata(z_rdata), .rdata_valid(z_rdata_valid), .rdata_last(z_rdata_last),
        .wr_done(z_wr_done), .busy(z_busy)
    );

    assign req_ready   = sel0 ? z_req_ready   : a_req_ready;
    assign wdata_ready = sel0 ? z_wdata_ready : a_wdata_ready;
    assign rdata       = sel0 ? z_rdata       : a_rdata;
    assign rdata_valid = sel0 ? z_rdata_valid : a_rdata_valid;
    assign rdata_last  = sel0 ? z_rdata_last  : a_rdata_last;
    assign wr_done     = sel0 ? z_wr_done     : a_wr_done;
    assign busy        = sel0 ? z_busy        : a_busy;

    int n_vec = 0;
    int n_err = 0;
    int lat   = 3;
    logic [31:0] mdl [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mval(input int a);
        if (mdl.exists(a)) return mdl[a];
`ifdef LINE_FILL_MEMORY_PATTERN_INIT_EN
        return 32'hA500_0000 | 32'(a);
`else
        return 32'h0;
`endif
    endfunction

    // Each task starts and ends at a negedge with the DUT idle.
    task automatic do_read(input int line, input int intrude);
        req_valid = 1'b1; req_write = 1'b0; req_line_addr = LINE_W'(line);
        @(posedge clk);
        for (int i = 0; i <= lat + 17; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b0;
                chk("rd_busy", busy, 1);
            end
            if (intrude >= 0 && i == 2) begin
                req_valid = 1'b1; req_line_addr = LINE_W'(intrude);
            end
            if (intrude >= 0 && i >= 2 && i < lat + 17) chk("rd_reject_rdy", req_ready, 0);
            chk("rd_valid", rdata_valid, 32'((i >= lat + 1) && (i <= lat + 16)));
            chk("rd_last", rdata_last, 32'(i == lat + 16));
            if (i >= lat + 1 && i <= lat + 16)
                chk("rd_data", rdata, mval(line * 16 + i - lat - 1));
            if (i == lat + 17) begin
                chk("rd_idle_rdy", req_ready, 1);
                chk("rd_idle_busy", busy, 0);
            end
        end
    endtask

    task automatic do_write(input int line, input bit rnd, input logic [31:0] base,
                            input int stall_at, input int abort_at);
        logic [31:0] d [16];
        int b = 0;
        int st = 0;
        bit done = 0;
        for (int k = 0; k < 16; k++) d[k] = rnd ? $urandom : base + 32'(k);
        req_valid = 1'b1; req_write = 1'b1; req_line_addr = LINE_W'(line);
        @(posedge clk);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b0;
                chk("wr_busy", busy, 1);
            end
            if (b == 16) begin
                wdata_valid = 1'b0;
                chk("wr_done", wr_done, 1);
                chk("wr_rdy_drop", wdata_ready, 0);
                chk("wr_idle_rdy", req_ready, 1);
                for (int k = 0; k < 16; k++) mdl[line * 16 + k] = d[k];
                done = 1;
            end else begin
                chk("wr_done_early", wr_done, 0);
                if (i <= lat) begin
                    chk("wr_rdy_early", wdata_ready, 0);
                end else begin
                    chk("wr_rdy", wdata_ready, 1);
                    if (abort_at >= 0 && b == abort_at) begin
                        rst_n = 1'b0; wdata_valid = 1'b0;
                        #1;
                        chk("abort_req_ready", req_ready, 1);
                        chk("abort_wdata_ready", wdata_ready, 0);
                        chk("abort_busy", busy, 0);
                        chk("abort_rdata", rdata, 0);
                        chk("abort_wr_done", wr_done, 0);
                        for (int k = 0; k < abort_at; k++) mdl[line * 16 + k] = d[k];
                        @(negedge clk);
                        chk("abort_wr_done2", wr_done, 0);
                        rst_n = 1'b1;
                        @(negedge clk);
                        chk("abort_wr_done3", wr_done, 0);
                        chk("abort_idle", req_ready, 1);
                        return;
                    end
                    if (stall_at >= 0 && b == stall_at && st < 3) begin
                        wdata_valid = 1'b0; st++;
                    end else begin
                        wdata = d[b]; wdata_valid = 1'b1; b++;
                    end
                end
            end
        end
        if (!done) begin
            wdata_valid = 1'b0;
            chk("wr_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_rdata_last", rdata_last, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Initial fill, write-back, read-back, then check the neighbour line.
        do_read(13'h1380, -1);
        do_write(13'h1380, 0, 32'h0C0C_0C00, -1, -1);
        do_read(13'h1380, -1);
        do_read(13'h1381, -1);

        // A write stalled after beat 5.
        do_write(13'h0A5A, 1, 0, 6, -1);
        do_read(13'h0A5A, -1);

        // A request while busy is held off and then accepted on the first idle cycle.
        do_write(13'h0777, 1, 0, -1, -1);
        do_read(13'h1380, 13'h0777);
        do_read(13'h0777, -1);

        // Reset after beat 7. The line is first filled with known old data.
        do_write(13'h0042, 1, 0, -1, -1);
        do_write(13'h0042, 1, 0, -1, 8);
        do_read(13'h0042, -1);

        // Random mix of operations over a few lines.
        for (int n = 0; n < 8; n++) begin
            int ln;
            ln = (n % 3 == 0) ? 13'h1FFF : int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(ln, 1, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1, -1);
            else
                do_read(ln, -1);
        end

        // LATENCY=0 instance. Its memory is untouched, so the model is cleared.
        sel0 = 1'b1; lat = 0; mdl.delete();
        @(negedge clk);
        do_read(13'h0010, -1);
        do_write(13'h0010, 1, 0, 3, -1);
        do_read(13'h0010, -1);
        do_read(13'h0011, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something hangs.
    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
